vga_frame_out: RTL and testbench

- Downstream consumer of the scaling datapath. Accepts the processed 8-bit grey pixel stream (pixel + valid) and writes it into an internal single-clock framebuffer.
- Generates 640x480@60 VGA timing from the same 25 MHz clk and scans the framebuffer out with the image centred on a black border.
- Output image size varies per algorithm: 160x120 after decimation or averaging, 640x480 after replication or zoom. Size is latched per frame.

---
 rtl/vga_frame_out_if.sv | 10 +
 rtl/vga_frame_out.sv | 136 +++++++++++++
 tb/tb_vga_frame_out.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/vga_frame_out_if.sv
// vga_frame_out_if: processed pixel stream and per-frame size from the scaling datapath
interface vga_frame_out_if;
  logic       start;
  logic [9:0] img_w;
  logic [9:0] img_h;
  logic [7:0] pix_in;
  logic       pix_valid;
  modport master (output start, img_w, img_h, pix_in, pix_valid);
  modport slave (input start, img_w, img_h, pix_in, pix_valid);
endinterface

// File: rtl/vga_frame_out.sv
// vga_frame_out: framebuffer writer plus centred 640x480@60 VGA scan-out.
// Defining VGA_TESTPAT_EN adds a test_mode input that shows a horizontal grey ramp.
module vga_frame_out #(
  parameter int FB_W = 640, FB_H = 480,
  parameter int H_ACT = 640, H_FP = 16, H_SYNC = 96, H_BP = 48,
  parameter int V_ACT = 480, V_FP = 10, V_SYNC = 2, V_BP = 33
) (
  input  logic clk,
  input  logic rst,
  vga_frame_out_if.slave s,
`ifdef VGA_TESTPAT_EN
  input  logic test_mode,
`endif
  output logic [7:0] vga_r, vga_g, vga_b,
  output logic vga_hs, vga_vs, vga_blank_n,
  output logic frame_done, wr_busy, ovf, size_err
);
  localparam int AW = $clog2(FB_W * FB_H);
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [9:0] lat_w, lat_h, lat_w_n, lat_h_n, wx, wy, wx_n, wy_n;
  logic done_n, ovf_n, serr_n, we, legal, last_x;
  logic [7:0] fb [FB_W*FB_H];
  logic [7:0] rd, pix;
  logic [AW-1:0] wa, ra;
  logic [9:0] h_cnt, v_cnt, sc_w, sc_h, x0, y0;
  logic act, win, hs0, vs0, act_d, win_d, hs_d, vs_d;
  assign legal = s.img_w != '0 && s.img_w <= 10'(FB_W) && s.img_h != '0 && s.img_h <= 10'(FB_H);
  assign last_x = wx == lat_w - 10'd1;
  assign wa = AW'(wy) * AW'(FB_W) + AW'(wx);
  assign wr_busy = state == WRITE;
  always_comb begin
    state_n = state;
    lat_w_n = lat_w;
    lat_h_n = lat_h;
    wx_n = wx;
    wy_n = wy;
    done_n = 1'b0;
    ovf_n = ovf;
    serr_n = size_err;
    we = 1'b0;
    if (s.start) begin
      state_n = legal ? WRITE : IDLE;
      serr_n = size_err | ~legal;
      lat_w_n = legal ? s.img_w : lat_w;
      lat_h_n = legal ? s.img_h : lat_h;
      wx_n = '0;
      wy_n = '0;
    end else if (s.pix_valid && state == WRITE) begin
      we = 1'b1;
      wx_n = last_x ? '0 : wx + 10'd1;
      wy_n = last_x ? wy + 10'd1 : wy;
      done_n = last_x && wy == lat_h - 10'd1;
      state_n = done_n ? DONE : WRITE;
    end else if (s.pix_valid && state == DONE) begin
      ovf_n = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lat_w <= 10'(FB_W);
      lat_h <= 10'(FB_H);
      wx <= '0;
      wy <= '0;
      frame_done <= 1'b0;
      ovf <= 1'b0;
      size_err <= 1'b0;
    end else begin
      state <= state_n;
      lat_w <= lat_w_n;
      lat_h <= lat_h_n;
      wx <= wx_n;
      wy <= wy_n;
      frame_done <= done_n;
      ovf <= ovf_n;
      size_err <= serr_n;
    end
  end
  assign x0 = (10'(H_ACT) - sc_w) >> 1;
  assign y0 = (10'(V_ACT) - sc_h) >> 1;
  assign act = h_cnt < 10'(H_ACT) && v_cnt < 10'(V_ACT);
  assign win = act && h_cnt >= x0 && h_cnt < x0 + sc_w && v_cnt >= y0 && v_cnt < y0 + sc_h;
  assign ra = AW'(v_cnt - y0) * AW'(FB_W) + AW'(h_cnt - x0);
  assign hs0 = !(h_cnt >= 10'(H_ACT + H_FP) && h_cnt < 10'(H_ACT + H_FP + H_SYNC));
  assign vs0 = !(v_cnt >= 10'(V_ACT + V_FP) && v_cnt < 10'(V_ACT + V_FP + V_SYNC));
  // Read-before-write: a same-address read sees the old pixel
  always_ff @(posedge clk) begin
    if (we) fb[wa] <= s.pix_in;
    rd <= fb[ra];
  end
`ifdef VGA_TESTPAT_EN
  logic [7:0] ramp_d;
  always_ff @(posedge clk) ramp_d <= h_cnt[9:2];
  assign pix = act_d && test_mode ? ramp_d : win_d ? rd : 8'd0;
`else
  assign pix = win_d ? rd : 8'd0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      sc_w <= 10'(FB_W);
      sc_h <= 10'(FB_H);
      act_d <= 1'b0;
      win_d <= 1'b0;
      hs_d <= 1'b1;
      vs_d <= 1'b1;
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_blank_n <= 1'b0;
    end else begin
      h_cnt <= h_cnt == 10'(H_TOT - 1) ? '0 : h_cnt + 10'd1;
      if (h_cnt == 10'(H_TOT - 1)) v_cnt <= v_cnt == 10'(V_TOT - 1) ? '0 : v_cnt + 10'd1;
      if (v_cnt == 10'(V_ACT) && h_cnt == '0) begin
        sc_w <= lat_w;
        sc_h <= lat_h;
      end
      act_d <= act;
      win_d <= win;
      hs_d <= hs0;
      vs_d <= vs0;
      vga_r <= pix;
      vga_g <= pix;
      vga_b <= pix;
      vga_hs <= hs_d;
      vga_vs <= vs_d;
      vga_blank_n <= act_d;
    end
  end
endmodule

// File: tb/tb_vga_frame_out.sv
// tb_vga_frame_out: randomized stream into a shrunken-raster vga_frame_out, checked every
// cycle against a frame-level model (pixel-count writer, arithmetic raster, delayed pipeline).
module tb_vga_frame_out;
  localparam int FW = 32, FH = 24, HA = 32, HF = 4, HS = 6, HB = 4, VA = 24, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] r, g, b;
  logic hs, vs, bl, fd, busy, ovf, serr;
  vga_frame_out_if bus();
  vga_frame_out #(.FB_W(FW), .FB_H(FH), .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .clk(clk), .rst(rst), .s(bus), .vga_r(r), .vga_g(g), .vga_b(b), .vga_hs(hs), .vga_vs(vs),
    .vga_blank_n(bl), .frame_done(fd), .wr_busy(busy), .ovf(ovf), .size_err(serr));
  always #5 clk = ~clk;
  typedef struct {int h; int v; int sw; logic [7:0] pix; bit known; bit hs; bit vs; bit bl;} px_t;
  int checks = 0, errors = 0;
  logic [7:0] fb [FW*FH];
  bit known [FW*FH];
  int t_h, t_v, lat_w, lat_h, sc_w, sc_h, n;
  int n_hs, n_vs, n_bl, n_fd, hits;
  bit writing, complete, m_ovf, m_serr, m_fd, probe;
  px_t p1, p2;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic px_t scan(int h, int v);
    px_t p;
    int x0, y0, a;
    bit w;
    x0 = (HA - sc_w) / 2;
    y0 = (VA - sc_h) / 2;
    w = h < HA && v < VA && h >= x0 && h < x0 + sc_w && v >= y0 && v < y0 + sc_h;
    p = '{h: h, v: v, sw: sc_w, pix: 8'd0, known: 1'b1, bl: h < HA && v < VA,
          hs: !(h >= HA + HF && h < HA + HF + HS), vs: !(v >= VA + VF && v < VA + VF + VS)};
    if (w) begin
      a = (v - y0) * FW + (h - x0);
      p.pix = fb[a];
      p.known = known[a];
    end
    return p;
  endfunction
  task automatic m_reset();
    t_h = 0; t_v = 0; lat_w = FW; lat_h = FH; sc_w = FW; sc_h = FH;
    writing = 0; complete = 0; m_ovf = 0; m_serr = 0; m_fd = 0;
    p1 = '{h: -1, v: -1, sw: 0, pix: 8'd0, known: 1'b1, hs: 1'b1, vs: 1'b1, bl: 1'b0};
    p2 = p1;
  endtask
  task automatic m_edge();
    px_t nx;
    int a;
    bit ok;
    nx = scan(t_h, t_v);
    p2 = p1;
    p1 = nx;
    m_fd = 0;
    if (t_v == VA && t_h == 0) begin
      sc_w = lat_w;
      sc_h = lat_h;
    end
    if (bus.start) begin
      ok = bus.img_w >= 1 && bus.img_w <= FW && bus.img_h >= 1 && bus.img_h <= FH;
      if (ok) begin
        lat_w = int'(bus.img_w); lat_h = int'(bus.img_h); n = 0; writing = 1;
      end else begin
        m_serr = 1; writing = 0;
      end
      complete = 0;
    end else if (writing && bus.pix_valid) begin
      a = (n / lat_w) * FW + n % lat_w;
      fb[a] = bus.pix_in;
      known[a] = 1;
      n++;
      if (n == lat_w * lat_h) begin
        writing = 0; complete = 1; m_fd = 1;
      end
    end else if (complete && bus.pix_valid) m_ovf = 1;
    t_h = (t_h + 1) % HT;
    if (t_h == 0) t_v = (t_v + 1) % VT;
  endtask
  task automatic tick();
    logic [30:0] exp, got, msk;
    if (rst) m_reset(); else m_edge();
    @(posedge clk);
    #1;
    msk = p2.known ? '1 : 31'h7f;
    exp = {p2.pix, p2.pix, p2.pix, p2.hs, p2.vs, p2.bl, m_fd, writing, m_ovf, m_serr};
    got = {r, g, b, hs, vs, bl, fd, busy, ovf, serr};
    check("outs", 64'(got & msk), 64'(exp & msk));
    n_hs += int'(!hs); n_vs += int'(!vs); n_bl += int'(bl); n_fd += int'(fd);
    if (probe && p2.sw == 8 && p2.h == 12 && p2.v == 9) begin
      check("px_top_left", 64'(r), 64'h00);
      hits++;
    end
    if (probe && p2.sw == 8 && p2.h == 19 && p2.v == 14) begin
      check("px_bot_right", 64'(r), 64'h0C);
      hits++;
    end
  endtask
  task automatic frame(input int w, input int hh, input int mode, input int npix);
    int k;
    bus.start = 1; bus.img_w = 10'(w); bus.img_h = 10'(hh);
    bus.pix_valid = 1'($urandom_range(0, 1)); bus.pix_in = 8'($urandom);
    tick();
    bus.start = 0;
    k = 0;
    while (k < npix) begin
      bus.pix_valid = $urandom_range(0, 3) != 0;
      bus.pix_in = mode == 0 ? 8'((k % w) + (k / w)) : mode == 1 ? 8'h80 : 8'($urandom);
      tick();
      if (bus.pix_valid) k++;
    end
    bus.pix_valid = 0;
  endtask
  initial begin
    bus.start = 0; bus.img_w = '0; bus.img_h = '0; bus.pix_in = '0; bus.pix_valid = 0;
    probe = 0; hits = 0;
    tick(); tick();
    check("rst_hs", 64'(hs), 64'd1);
    check("rst_blank", 64'(bl), 64'd0);
    rst = 0;
    n_hs = 0; n_vs = 0; n_bl = 0;
    repeat (HT * VT) tick();
    check("hs_low_cycles", 64'(n_hs), 64'(HS * VT));
    check("vs_low_cycles", 64'(n_vs), 64'(VS * HT));
    check("blank_hi_cycles", 64'(n_bl), 64'(HA * VA));
    n_fd = 0;
    frame(8, 6, 0, 48);
    tick();
    check("frame_done_once", 64'(n_fd), 64'd1);
    probe = 1;
    repeat (3 * HT * VT) tick();
    probe = 0;
    check("probe_hits", 64'(hits >= 2), 64'd1);
    frame(32, 24, 1, FW * FH);
    repeat (2 * HT * VT) tick();
    repeat (3) begin
      bus.pix_valid = 1; bus.pix_in = 8'($urandom); tick();
      bus.pix_valid = 0; tick();
    end
    check("ovf_set", 64'(ovf), 64'd1);
    frame(8, 6, 2, 48);
    check("ovf_sticky", 64'(ovf), 64'd1);
    repeat (HT * VT) tick();
    bus.start = 1; bus.img_w = 10'd0; bus.img_h = 10'd6; tick();
    check("size_err_w0", 64'(serr), 64'd1);
    check("idle_after_err", 64'(busy), 64'd0);
    bus.img_w = 10'd700; tick();
    bus.start = 0;
    repeat (2 * HT * VT) tick();
    frame(32, 24, 2, 300);
    frame(32, 24, 2, FW * FH);
    frame(16, 12, 2, 100);
    rst = 1; tick();
    check("midrst_hs", 64'(hs), 64'd1);
    check("midrst_vs", 64'(vs), 64'd1);
    check("midrst_flags", 64'({fd, busy, ovf, serr}), 64'd0);
    rst = 0;
    repeat (HT * VT) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
